// File: rtl/stdp_sweep_ctrl.sv
// Read/write-back sweep controller for per-synapse STDP state (weight, r1, o1).
// Define STDP_DEBUG_READ_EN to add a combinational debug read port (dbg_*).
module stdp_sweep_ctrl #(
  parameter int NUM_SYN = 16,
  parameter int TRACE_WIDTH = 18,
  parameter int WEIGHT_WIDTH = 32,
  parameter logic signed [WEIGHT_WIDTH-1:0] INIT_WEIGHT = '0,
  localparam int IDX_W = $clog2(NUM_SYN)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           step_valid,
  output logic                           step_ready,
  input  logic [NUM_SYN-1:0]             pre_spikes,
  input  logic                           post_spike,
  output logic                           done,
  output logic                           busy,
  output logic                           core_trigger,
  output logic                           core_pre_edge,
  output logic                           core_post_edge,
  output logic signed [WEIGHT_WIDTH-1:0] core_weight_in,
  output logic signed [TRACE_WIDTH-1:0]  core_r1_in,
  output logic signed [TRACE_WIDTH-1:0]  core_o1_in,
  input  logic signed [WEIGHT_WIDTH-1:0] core_weight_out,
  input  logic signed [TRACE_WIDTH-1:0]  core_r1_out,
  input  logic signed [TRACE_WIDTH-1:0]  core_o1_out
`ifdef STDP_DEBUG_READ_EN
  ,
  input  logic [IDX_W-1:0]               dbg_addr,
  output logic signed [WEIGHT_WIDTH-1:0] dbg_weight,
  output logic signed [TRACE_WIDTH-1:0]  dbg_r1,
  output logic signed [TRACE_WIDTH-1:0]  dbg_o1
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]               idx_q;
  logic [NUM_SYN-1:0]             pre_prev_q;
  logic                           post_prev_q;
  logic [NUM_SYN-1:0]             pre_edge_q;
  logic                           post_edge_q;
  logic signed [WEIGHT_WIDTH-1:0] hold_weight_q;
  logic signed [TRACE_WIDTH-1:0]  hold_r1_q;
  logic signed [TRACE_WIDTH-1:0]  hold_o1_q;

  logic signed [WEIGHT_WIDTH-1:0] weight_mem [NUM_SYN];
  logic signed [TRACE_WIDTH-1:0]  r1_mem     [NUM_SYN];
  logic signed [TRACE_WIDTH-1:0]  o1_mem     [NUM_SYN];

  logic accept;
  logic last_syn;

  assign accept   = step_valid && step_ready;
  assign last_syn = (idx_q == IDX_W'(NUM_SYN - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    step_ready     = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    core_trigger   = 1'b0;
    core_pre_edge  = 1'b0;
    core_post_edge = 1'b0;
    case (state_q)
      S_IDLE: begin
        step_ready = 1'b1;
        busy       = 1'b0;
        if (step_valid) state_d = enable ? S_ISSUE : S_DONE;
      end
      S_ISSUE: begin
        core_trigger   = 1'b1;
        core_pre_edge  = pre_edge_q[idx_q];
        core_post_edge = post_edge_q;
        state_d        = S_COMMIT;
      end
      S_COMMIT: state_d = last_syn ? S_DONE : S_ISSUE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stored state is presented continuously; the core only matters while core_trigger is high.
  assign core_weight_in = weight_mem[idx_q];
  assign core_r1_in     = r1_mem[idx_q];
  assign core_o1_in     = o1_mem[idx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= '0;
      pre_prev_q    <= '0;
      post_prev_q   <= 1'b0;
      pre_edge_q    <= '0;
      post_edge_q   <= 1'b0;
      hold_weight_q <= '0;
      hold_r1_q     <= '0;
      hold_o1_q     <= '0;
      for (int i = 0; i < NUM_SYN; i++) begin
        weight_mem[i] <= INIT_WEIGHT;
        r1_mem[i]     <= '0;
        o1_mem[i]     <= '0;
      end
    end else begin
      if (accept) begin
        // History tracks the levels even when plasticity is disabled.
        pre_edge_q  <= pre_spikes & ~pre_prev_q;
        post_edge_q <= post_spike & ~post_prev_q;
        pre_prev_q  <= pre_spikes;
        post_prev_q <= post_spike;
        idx_q       <= '0;
      end
      if (state_q == S_ISSUE) begin
        hold_weight_q <= core_weight_out;
        hold_r1_q     <= core_r1_out;
        hold_o1_q     <= core_o1_out;
      end
      if (state_q == S_COMMIT) begin
        weight_mem[idx_q] <= hold_weight_q;
        r1_mem[idx_q]     <= hold_r1_q;
        o1_mem[idx_q]     <= hold_o1_q;
        if (!last_syn) idx_q <= idx_q + 1'b1;
      end
      if (state_q == S_DONE) idx_q <= '0;
    end
  end

`ifdef STDP_DEBUG_READ_EN
  assign dbg_weight = weight_mem[dbg_addr];
  assign dbg_r1     = r1_mem[dbg_addr];
  assign dbg_o1     = o1_mem[dbg_addr];
`endif

endmodule

// File: tb/tb_stdp_sweep_ctrl.sv
// Scoreboard bench for stdp_sweep_ctrl: a simple stand-in core and a per-step model of the sweep.
// Define STDP_DEBUG_READ_EN to also check the debug read port.
module tb_stdp_sweep_ctrl;
  localparam int NS = 4;
  localparam int TW = 18;
  localparam int WW = 32;
  localparam logic signed [WW-1:0] INIT_W = -32'sd3;

  logic clk, rst, enable, step_valid, step_ready, post_spike, done, busy;
  logic core_trigger, core_pre_edge, core_post_edge;
  logic [NS-1:0] pre_spikes;
  logic signed [WW-1:0] core_weight_in, core_weight_out;
  logic signed [TW-1:0] core_r1_in, core_o1_in, core_r1_out, core_o1_out;
`ifdef STDP_DEBUG_READ_EN
  logic [1:0] dbg_addr;
  logic signed [WW-1:0] dbg_weight;
  logic signed [TW-1:0] dbg_r1, dbg_o1;
`endif

  stdp_sweep_ctrl #(.NUM_SYN(NS), .TRACE_WIDTH(TW), .WEIGHT_WIDTH(WW), .INIT_WEIGHT(INIT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .step_valid(step_valid), .step_ready(step_ready),
    .pre_spikes(pre_spikes), .post_spike(post_spike), .done(done), .busy(busy),
    .core_trigger(core_trigger), .core_pre_edge(core_pre_edge), .core_post_edge(core_post_edge),
    .core_weight_in(core_weight_in), .core_r1_in(core_r1_in), .core_o1_in(core_o1_in),
    .core_weight_out(core_weight_out), .core_r1_out(core_r1_out), .core_o1_out(core_o1_out)
`ifdef STDP_DEBUG_READ_EN
    , .dbg_addr(dbg_addr), .dbg_weight(dbg_weight), .dbg_r1(dbg_r1), .dbg_o1(dbg_o1)
`endif
  );

  // Stand-in core: post edge potentiates by r1/16, pre edge depresses by o1/16, traces reset or decay.
  function automatic logic signed [WW-1:0] core_w(input logic pre, input logic post,
      input logic signed [WW-1:0] w, input logic signed [TW-1:0] r1, input logic signed [TW-1:0] o1);
    logic signed [WW-1:0] lt, ld;
    lt = r1;
    ld = o1;
    lt = post ? (lt >>> 4) : '0;
    ld = pre ? (ld >>> 4) : '0;
    return w + lt - ld;
  endfunction

  function automatic logic signed [TW-1:0] core_r1(input logic pre, input logic signed [TW-1:0] r1);
    return pre ? 18'sd256 : r1 - (r1 >>> 4);
  endfunction

  function automatic logic signed [TW-1:0] core_o1(input logic post, input logic signed [TW-1:0] o1);
    return post ? 18'sd256 : o1 - (o1 >>> 5);
  endfunction

  assign core_weight_out = core_w(core_pre_edge, core_post_edge, core_weight_in, core_r1_in, core_o1_in);
  assign core_r1_out     = core_r1(core_pre_edge, core_r1_in);
  assign core_o1_out     = core_o1(core_post_edge, core_o1_in);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic pre;
    logic post;
    logic [WW-1:0] w;
    logic [TW-1:0] r1;
    logic [TW-1:0] o1;
  } issue_t;

  issue_t exp_q[$];
  int     done_q[$];
  int     total = 0;
  int     bad = 0;

  logic signed [WW-1:0] m_w  [NS];
  logic signed [TW-1:0] m_r1 [NS];
  logic signed [TW-1:0] m_o1 [NS];
  logic [NS-1:0]        m_pre_prev;
  logic                 m_post_prev;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_w[i]  = INIT_W;
      m_r1[i] = '0;
      m_o1[i] = '0;
    end
    m_pre_prev  = '0;
    m_post_prev = 1'b0;
  endtask

  // One accepted step: compute edges, then every synapse sees the core applied to its stored state.
  task automatic model_step(input logic en, input logic [NS-1:0] pre, input logic post, input int acc);
    logic [NS-1:0] pe;
    logic po;
    issue_t e;
    pe = pre & ~m_pre_prev;
    po = post & ~m_post_prev;
    m_pre_prev  = pre;
    m_post_prev = post;
    if (en) begin
      for (int i = 0; i < NS; i++) begin
        e.pre  = pe[i];
        e.post = po;
        e.w    = m_w[i];
        e.r1   = m_r1[i];
        e.o1   = m_o1[i];
        exp_q.push_back(e);
        m_w[i]  = core_w(pe[i], po, m_w[i], m_r1[i], m_o1[i]);
        m_r1[i] = core_r1(pe[i], m_r1[i]);
        m_o1[i] = core_o1(po, m_o1[i]);
      end
    end
    // done is high in cycle 2*NS+1 (or 1) after the accept edge; cycle 1 carries cyc == acc
    done_q.push_back(acc + (en ? 2 * NS : 0));
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, expv, cyc);
    end
  endtask

  issue_t mon_got, mon_exp;
  int     mon_done;

  always @(negedge clk) begin
    if (!rst) begin
      if (core_trigger) begin
        mon_got.pre  = core_pre_edge;
        mon_got.post = core_post_edge;
        mon_got.w    = core_weight_in;
        mon_got.r1   = core_r1_in;
        mon_got.o1   = core_o1_in;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL issue_unexpected cyc=%0d", cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            bad++;
            $display("FAIL issue_inputs cyc=%0d got pre=%0b post=%0b w=%0d r1=%0d o1=%0d exp pre=%0b post=%0b w=%0d r1=%0d o1=%0d",
                     cyc, mon_got.pre, mon_got.post, $signed(mon_got.w), $signed(mon_got.r1), $signed(mon_got.o1),
                     mon_exp.pre, mon_exp.post, $signed(mon_exp.w), $signed(mon_exp.r1), $signed(mon_exp.o1));
          end
        end
      end
      if (done) begin
        total++;
        if (done_q.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected cyc=%0d", cyc);
        end else begin
          mon_done = done_q.pop_front();
          if (cyc != mon_done) begin
            bad++;
            $display("FAIL done_cycle got=%0d exp=%0d", cyc, mon_done);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step_ready && n < 100);
    if (!step_ready) begin
      total++;
      bad++;
      $display("FAIL idle_timeout cyc=%0d", cyc);
    end
`ifdef STDP_DEBUG_READ_EN
    for (int i = 0; i < NS; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk("dbg_weight", 64'(dbg_weight), 64'(m_w[i]));
      chk("dbg_r1", 64'(dbg_r1), 64'(m_r1[i]));
      chk("dbg_o1", 64'(dbg_o1), 64'(m_o1[i]));
    end
`endif
  endtask

  task automatic accept_step(input logic en, input logic [NS-1:0] pre, input logic post);
    @(negedge clk);
    enable     = en;
    pre_spikes = pre;
    post_spike = post;
    step_valid = 1'b1;
    @(posedge clk);
    #1;
    model_step(en, pre, post, cyc);
  endtask

  task automatic do_step(input logic en, input logic [NS-1:0] pre, input logic post);
    accept_step(en, pre, post);
    step_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    step_valid = 1'b0;
    pre_spikes = '0;
    post_spike = 1'b0;
`ifdef STDP_DEBUG_READ_EN
    dbg_addr = '0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_step_ready", 64'(step_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_trigger", 64'(core_trigger), 64'd0);
    chk("rst_edges", 64'({core_pre_edge, core_post_edge}), 64'd0);
    rst = 1'b0;

    do_step(1'b1, 4'b0001, 1'b0);
    do_step(1'b1, 4'b0001, 1'b1);
    do_step(1'b1, 4'b0010, 1'b1);
    do_step(1'b0, 4'b1111, 1'b0);
    do_step(1'b1, 4'b1111, 1'b0);

    // step_valid held through the sweep: one sweep only, never ready while busy
    accept_step(1'b1, 4'b0101, 1'b1);
    begin
      int k;
      for (k = 0; k < 50; k++) begin
        @(negedge clk);
        chk("held_ready_low", 64'(step_ready), 64'd0);
        chk("held_busy", 64'(busy), 64'd1);
        if (done) break;
      end
      if (k == 50) begin
        total++;
        bad++;
        $display("FAIL held_done_timeout cyc=%0d", cyc);
      end
    end
    step_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    for (int s = 0; s < 25; s++)
      do_step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    // reset in the 4th busy cycle of a sweep
    accept_step(1'b1, 4'b1010, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    step_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    done_q.delete();
    model_reset();
    chk("midrst_ready", 64'(step_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_trigger", 64'(core_trigger), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", 64'(done), 64'd0);
    end
    do_step(1'b1, 4'b0011, 1'b1);
    do_step(1'b1, 4'b0100, 1'b1);

    repeat (3) @(negedge clk);
    chk("issue_q_drained", 64'(exp_q.size()), 64'd0);
    chk("done_q_drained", 64'(done_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
